hlpte_itq_decoder: RTL and testbench

//  Decoder side of the HLPTE transform/quant path. Receives 16 quantized levels of one 4x4

---
 rtl/hlpte_pkg.sv | 62 ++++++
 rtl/hlpte_itq_butterfly4.sv | 24 ++
 rtl/hlpte_itq_decoder.sv | 154 +++++++++++++++
 tb/tb_hlpte_itq_decoder.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/hlpte_pkg.sv
// Shared types, constants and lookup helpers for the HLPTE inverse transform/quant decoder.
package hlpte_pkg;

    localparam int HLPTE_LVL_W = 16;
    localparam int HLPTE_ACC_W = 24;
    localparam int HLPTE_OUT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ROW,
        ST_COL,
        ST_OUT
    } state_t;

    typedef enum logic [1:0] {
        CLS_A,
        CLS_B,
        CLS_C
    } pos_cls_t;

    // Raster index: row parity is idx[2], column parity is idx[0].
    function automatic pos_cls_t cls(input logic [3:0] idx);
        if (!idx[2] && !idx[0]) return CLS_A;
        if (idx[2] && idx[0]) return CLS_B;
        return CLS_C;
    endfunction

    function automatic logic [2:0] qp_div6(input logic [4:0] q);
        if (q >= 5'd30) return 3'd5;
        if (q >= 5'd24) return 3'd4;
        if (q >= 5'd18) return 3'd3;
        if (q >= 5'd12) return 3'd2;
        if (q >= 5'd6) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [2:0] qp_mod6(input logic [4:0] q);
        return 3'(q - 5'(6 * qp_div6(q)));
    endfunction

    function automatic logic [4:0] vscale(input logic [2:0] m, input pos_cls_t c);
        logic [4:0] v;
        v = 5'd0;
        case (c)
            CLS_A: case (m)
                3'd0: v = 5'd10; 3'd1: v = 5'd11; 3'd2: v = 5'd13;
                3'd3: v = 5'd14; 3'd4: v = 5'd16; default: v = 5'd18;
            endcase
            CLS_B: case (m)
                3'd0: v = 5'd16; 3'd1: v = 5'd18; 3'd2: v = 5'd20;
                3'd3: v = 5'd23; 3'd4: v = 5'd25; default: v = 5'd29;
            endcase
            default: case (m)
                3'd0: v = 5'd13; 3'd1: v = 5'd14; 3'd2: v = 5'd16;
                3'd3: v = 5'd18; 3'd4: v = 5'd20; default: v = 5'd23;
            endcase
        endcase
        return v;
    endfunction

endpackage

// File: rtl/hlpte_itq_butterfly4.sv
// Combinational 4-point inverse integer transform; shared by the row and column passes.
module hlpte_itq_butterfly4
    import hlpte_pkg::*;
#(
    parameter int ACC_W = HLPTE_ACC_W
) (
    input  logic signed [ACC_W-1:0] d_i [4],
    output logic signed [ACC_W-1:0] f_o [4]
);

    logic signed [ACC_W-1:0] e0, e1, e2, e3;

    always_comb begin
        e0 = d_i[0] + d_i[2];
        e1 = d_i[0] - d_i[2];
        e2 = (d_i[1] >>> 1) - d_i[3];
        e3 = d_i[1] + (d_i[3] >>> 1);
        f_o[0] = e0 + e3;
        f_o[1] = e1 + e2;
        f_o[2] = e1 - e2;
        f_o[3] = e0 - e3;
    end

endmodule

// File: rtl/hlpte_itq_decoder.sv
// 4x4 dequant + inverse transform: loads 16 levels, runs row/column passes in place,
// then streams 16 rounded, saturated residuals.
module hlpte_itq_decoder
    import hlpte_pkg::*;
#(
    parameter int LVL_W = HLPTE_LVL_W,
    parameter int ACC_W = HLPTE_ACC_W,
    parameter int OUT_W = HLPTE_OUT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [LVL_W-1:0] coeff,
    input  logic [4:0]              qp,
    output logic                    out_valid,
    output logic signed [OUT_W-1:0] out_value
);

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 <<< (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(1 <<< (OUT_W - 1)));
    localparam logic signed [ACC_W-1:0] RND     = ACC_W'(32);

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [1:0]              pass_q, pass_d;
    logic [4:0]              qp_q, qp_d;
    logic                    accept;

    logic signed [ACC_W-1:0] buf_q [16];
    logic signed [ACC_W-1:0] bf_in [4];
    logic signed [ACC_W-1:0] bf_out [4];

    logic [4:0]              qp_sel;
    logic signed [ACC_W-1:0] coeff_ext, scale_ext, dq;
    logic signed [ACC_W-1:0] rnd, shr;
    logic signed [OUT_W-1:0] sat_val;

    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_value_q;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_LOAD);
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_value = out_value_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        qp_d    = qp_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    qp_d    = qp;
                    cnt_d   = 4'd1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        pass_d  = 2'd0;
                        state_d = ST_ROW;
                    end
                end
            end
            ST_ROW: begin
                pass_d = pass_q + 2'd1;
                if (pass_q == 2'd3) state_d = ST_COL;
            end
            ST_COL: begin
                pass_d = pass_q + 2'd1;
                if (pass_q == 2'd3) begin
                    cnt_d   = 4'd0;
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15) state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = 4'd0;
                pass_d  = 2'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            pass_q  <= 2'd0;
            qp_q    <= 5'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pass_q  <= pass_d;
            qp_q    <= qp_d;
        end
    end

    // The first beat of a block dequantizes with the live qp, later beats with the latched one.
    always_comb begin
        qp_sel    = (state_q == ST_IDLE) ? qp : qp_q;
        coeff_ext = {{(ACC_W - LVL_W){coeff[LVL_W-1]}}, coeff};
        scale_ext = $signed({{(ACC_W - 5){1'b0}}, vscale(qp_mod6(qp_sel), cls(cnt_q))});
        dq        = (coeff_ext * scale_ext) <<< qp_div6(qp_sel);
    end

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            if (state_q == ST_COL) bf_in[k] = buf_q[{2'(k), pass_q}];
            else                   bf_in[k] = buf_q[{pass_q, 2'(k)}];
        end
    end

    hlpte_itq_butterfly4 #(.ACC_W(ACC_W)) u_bfly (
        .d_i (bf_in),
        .f_o (bf_out)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            buf_q[cnt_q] <= dq;
        end else if (state_q == ST_ROW) begin
            for (int k = 0; k < 4; k++) buf_q[{pass_q, 2'(k)}] <= bf_out[k];
        end else if (state_q == ST_COL) begin
            for (int k = 0; k < 4; k++) buf_q[{2'(k), pass_q}] <= bf_out[k];
        end
    end

    always_comb begin
        rnd = buf_q[cnt_q] + RND;
        shr = rnd >>> 6;
        if (shr > SAT_MAX)      sat_val = SAT_MAX[OUT_W-1:0];
        else if (shr < SAT_MIN) sat_val = SAT_MIN[OUT_W-1:0];
        else                    sat_val = shr[OUT_W-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_value_q <= '0;
        end else begin
            out_valid_q <= (state_q == ST_OUT);
            if (state_q == ST_OUT) out_value_q <= sat_val;
        end
    end

endmodule

// File: tb/tb_hlpte_itq_decoder.sv
// Scoreboard bench for hlpte_itq_decoder: DC vector table, corner-case sequences, random blocks.
module tb_hlpte_itq_decoder;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [15:0] coeff = '0;
    logic [4:0]         qp = '0;
    logic               out_valid;
    logic signed [15:0] out_value;

    always #5 clk = ~clk;

    hlpte_itq_decoder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .coeff     (coeff),
        .qp        (qp),
        .out_valid (out_valid),
        .out_value (out_value)
    );

    int checks = 0;
    int errors = 0;
    int sb[$];
    int edge_cnt = 0;
    int n_pop = 0;
    int last_in_edge = 0;
    bit lat_armed = 1'b0;
    int mon_exp;
    int vtab[3][6] = '{'{10, 11, 13, 14, 16, 18},
                       '{16, 18, 20, 23, 25, 29},
                       '{13, 14, 16, 18, 20, 23}};

    typedef struct {
        int c0;
        int q;
        int exp;
        bit gap;
    } vec_t;
    vec_t vecs[6];

    always @(posedge clk) edge_cnt++;

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (lat_armed) begin
                lat_armed = 1'b0;
                checks++;
                if (edge_cnt - last_in_edge != 9) begin
                    errors++;
                    $display("FAIL latency: got %0d cycles, want 9", edge_cnt - last_in_edge);
                end
            end
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_beat: got value %0d with nothing expected", out_value);
            end else begin
                mon_exp = sb.pop_front();
                if (int'(out_value) != mon_exp) begin
                    errors++;
                    $display("FAIL residual beat %0d: got %0d want %0d", n_pop, out_value, mon_exp);
                end
            end
            n_pop++;
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    function automatic void bf4(input int x[4], output int y[4]);
        int e0, e1, e2, e3;
        e0 = x[0] + x[2];
        e1 = x[0] - x[2];
        e2 = (x[1] >>> 1) - x[3];
        e3 = x[1] + (x[3] >>> 1);
        y = '{e0 + e3, e1 + e2, e1 - e2, e0 - e3};
    endfunction

    function automatic void model(input int lv[16], input int q, output int res[16]);
        int d[16];
        int tin[4];
        int tout[4];
        int r, c, k, t;
        for (int i = 0; i < 16; i++) begin
            r = i / 4;
            c = i % 4;
            if (r % 2 == 0 && c % 2 == 0)      k = 0;
            else if (r % 2 == 1 && c % 2 == 1) k = 1;
            else                               k = 2;
            d[i] = (lv[i] * vtab[k][q % 6]) <<< (q / 6);
        end
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 4; j++) tin[j] = d[4 * p + j];
            bf4(tin, tout);
            for (int j = 0; j < 4; j++) d[4 * p + j] = tout[j];
        end
        for (int p = 0; p < 4; p++) begin
            for (int j = 0; j < 4; j++) tin[j] = d[4 * j + p];
            bf4(tin, tout);
            for (int j = 0; j < 4; j++) d[4 * j + p] = tout[j];
        end
        for (int i = 0; i < 16; i++) begin
            t = (d[i] + 32) >>> 6;
            if (t > 32767) t = 32767;
            if (t < -32768) t = -32768;
            res[i] = t;
        end
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 want 1 within 100 cycles");
        end
    endtask

    task automatic send_block(input int lv[16], input int q, input bit gap);
        for (int i = 0; i < 16; i++) begin
            if (gap && (i % 5 == 4)) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    in_valid = 1'b0;
                    coeff = 16'($urandom);
                    qp = 5'($urandom);
                end
            end
            @(negedge clk);
            in_valid = 1'b1;
            coeff = 16'(lv[i]);
            qp = (i == 0) ? 5'(q) : 5'($urandom);
            wait_ready();
            if (i == 15) begin
                last_in_edge = edge_cnt + 1;
                lat_armed = 1'b1;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic push_model(input int lv[16], input int q);
        int res[16];
        model(lv, q, res);
        for (int i = 0; i < 16; i++) sb.push_back(res[i]);
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("drain_remaining", sb.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lv[16];
        int base;
        int n;
        bit ready_low;

        vecs[0] = '{c0: 0,     q: 20, exp: 0,      gap: 1'b0};
        vecs[1] = '{c0: 16,    q: 0,  exp: 3,      gap: 1'b0};
        vecs[2] = '{c0: -16,   q: 0,  exp: -2,     gap: 1'b1};
        vecs[3] = '{c0: 1,     q: 31, exp: 6,      gap: 1'b0};
        vecs[4] = '{c0: 100,   q: 6,  exp: 31,     gap: 1'b0};
        vecs[5] = '{c0: -2047, q: 30, exp: -10235, gap: 1'b1};

        repeat (3) @(negedge clk);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_out_value", int'(out_value), 0);
        chk("reset_in_ready", int'(in_ready), 1);
        rst = 1'b0;
        @(negedge clk);

        // DC-only blocks, sent back to back
        for (int v = 0; v < 6; v++) begin
            lv = '{default: 0};
            lv[0] = vecs[v].c0;
            for (int i = 0; i < 16; i++) sb.push_back(vecs[v].exp);
            send_block(lv, vecs[v].q, vecs[v].gap);
        end
        drain();
        chk("out_value_hold", int'(out_value), -10235);

        // in_valid held with junk while busy must be ignored
        for (int i = 0; i < 16; i++) lv[i] = int'($urandom_range(0, 200)) - 100;
        push_model(lv, 13);
        send_block(lv, 13, 1'b1);
        ready_low = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            coeff = 16'($urandom);
            qp = 5'($urandom);
            if (in_ready) ready_low = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("in_ready_low_busy", int'(ready_low), 1);
        drain();
        lv = '{default: 0};
        lv[0] = 16;
        for (int i = 0; i < 16; i++) sb.push_back(3);
        send_block(lv, 0, 1'b1);
        drain();

        // reset during the output phase
        lv = '{default: 0};
        lv[0] = 16;
        for (int i = 0; i < 16; i++) sb.push_back(3);
        base = n_pop;
        send_block(lv, 0, 1'b0);
        n = 0;
        while (n_pop < base + 5 && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("pops_before_reset", n_pop - base, 5);
        rst = 1'b1;
        #1;
        chk("midreset_out_valid", int'(out_valid), 0);
        chk("midreset_out_value", int'(out_value), 0);
        sb.delete();
        lat_armed = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        base = n_pop;
        repeat (30) @(negedge clk);
        chk("beats_after_reset", n_pop - base, 0);
        chk("in_ready_after_reset", int'(in_ready), 1);
        for (int i = 0; i < 16; i++) sb.push_back(3);
        send_block(lv, 0, 1'b0);
        drain();

        // random sparse blocks against the reference model
        for (int b = 0; b < 8; b++) begin
            int q;
            q = int'($urandom_range(0, 31));
            for (int i = 0; i < 16; i++)
                lv[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(0, 400)) - 200;
            push_model(lv, q);
            send_block(lv, q, b[0]);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
